fifo_occupancy_ctrl: RTL and testbench
======================================

Name: fifo_occupancy_ctrl

Overview:
Write-side pointer and occupancy/flag controller for the FIFO. It accepts push/pop requests, generates the RAM write enable and write address, and tracks occupancy. It produces full/empty/almost flags, including the empty_flag consumed by the read-pointer stage. It also latches sticky overflow/underflow errors for the board LEDs.

Parameters:
W_DEPTH, fifo_pkg::W_DEPTH (8), number of FIFO entries; power of two, >= 4
AF_TH, W_DEPTH-2, almost_full asserted when count >= AF_TH
AE_TH, 2, almost_empty asserted when count <= AE_TH

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
push  in  1  write request, sampled each clk
pop  in  1  read request, sampled each clk (same signal fed to read-pointer stage)
clear_err  in  1  clears sticky error flags
ena_wr  out  1  RAM write enable, one-cycle pulse per accepted push
addr_wr  out  addr_t  RAM write address
full_flag  out  1  count == W_DEPTH
empty_flag  out  1  count == 0
almost_full  out  1  count >= AF_TH
almost_empty  out  1  count <= AE_TH
count  out  cnt_t  occupancy, 0..W_DEPTH
overflow_err  out  1  sticky: push attempted while full and not accepted
underflow_err  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst=1 at edge): head_r=0, count=0, ena_wr=0, empty_flag=1, almost_empty=1, full_flag=0, almost_full=0, overflow_err=0, underflow_err=0. rst overrides all other inputs. Mid-operation reset discards contents; no pending write completes.
- addr_wr = head_r, combinational from register. On an accepted push, ena_wr=1 in the next cycle with addr_wr still equal to the slot being written. head_r advances one cycle later, in the same edge at which ena_wr drops. This keeps address and enable aligned for the RAM.
- Accept rules, evaluated on registered flags at the edge:
  - push_ok = push & (~full_flag | pop).
  - pop_ok = pop & ~empty_flag.
- Counting:
  - push_ok & ~pop_ok: count+1.
  - pop_ok & ~push_ok: count-1.
  - Both or neither: count unchanged.
- Simultaneous push+pop:
  - When empty: push accepted, pop rejected, underflow_err set.
  - When full: both accepted, count stays W_DEPTH, no overflow.
- Pointer wrap: head_r goes from W_DEPTH-1 to 0. Modulo arithmetic on addr_t, no explicit compare needed for power-of-two depth.
- Flags are registered and computed from next count. They change on the same edge as count, with one-cycle latency from request.
- count never exceeds W_DEPTH and never goes below 0. Must be checked by assertion.
- Errors:
  - overflow_err set when push & full_flag & ~pop.
  - underflow_err set when pop & empty_flag.
  - Both hold until clear_err=1.
  - If clear_err and a new error occur in the same cycle, set wins.
- Width rule: cnt_t is $clog2(W_DEPTH+1) bits. For W_DEPTH=8: addr_t is 3 bits, cnt_t is 4 bits.
- No FSM states beyond counters. The write port uses a two-phase pipeline: IDLE and WRITE, where WRITE is the ena_wr cycle. A push accepted during WRITE starts the next WRITE back-to-back, so throughput is 1 push/cycle.

Decomposition:
- fifo_pkg holds: W_DEPTH, addr_t, new cnt_t typedef, AF_TH/AE_TH defaults.
- One natural sub-module: fifo_flag_gen. It is combinational next-count to flags, so it is reusable by an async variant later.
- The pointer/counter logic stays in the top.

Test Plan:
1. Reset then idle 5 cycles -> empty_flag=1, almost_empty=1, count=0, ena_wr=0, addr_wr=0, no errors.
2. Push 8 consecutive cycles (W_DEPTH=8):
   - ena_wr high 8 cycles.
   - addr_wr steps 0..7.
   - almost_full rises when count=6.
   - full_flag=1 at count=8.
   - head_r wraps to 0.
3. Full, push alone 1 cycle -> count stays 8, ena_wr=0, overflow_err=1 and stays 1 until clear_err pulse, then 0.
4. Full, push+pop same cycle -> count stays 8, ena_wr pulses at addr 0, overflow_err=0.
5. Empty, pop alone and push+pop -> underflow_err=1 both times. Push+pop case gives count=1, empty_flag=0 next cycle.
6. Fill to 4, assert rst mid-stream with push=1 -> next cycle count=0, empty_flag=1, ena_wr=0, addr_wr=0, errors cleared.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared depth, address/count types, flag threshold defaults
//               and write-port state encoding for the FIFO control slice.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int W_DEPTH   = 8;                      // entries, power of two >= 4
    localparam int W_ADDR    = $clog2(W_DEPTH);
    localparam int W_CNT     = $clog2(W_DEPTH + 1);    // must represent 0..W_DEPTH
    localparam int AF_TH_DEF = W_DEPTH - 2;
    localparam int AE_TH_DEF = 2;

    typedef logic [W_ADDR-1:0] addr_t;
    typedef logic [W_CNT-1:0]  cnt_t;

    // Write port: WRITE is the cycle in which ena_wr is driven to the RAM
    typedef enum logic [0:0] {
        WR_IDLE  = 1'b0,
        WR_WRITE = 1'b1
    } wr_state_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_flag_gen.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flag_gen
// Description : Purely combinational next-count to status-flag decode.
//               Kept clock-free so an async FIFO variant can reuse it.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flag_gen
    import fifo_pkg::*;
#(
    parameter int AF_TH = AF_TH_DEF,
    parameter int AE_TH = AE_TH_DEF
) (
    input  cnt_t i_count_next,
    output logic o_full,
    output logic o_empty,
    output logic o_almost_full,
    output logic o_almost_empty
);

    localparam cnt_t c_full = cnt_t'(W_DEPTH);
    localparam cnt_t c_af   = cnt_t'(AF_TH);
    localparam cnt_t c_ae   = cnt_t'(AE_TH);

    // Threshold compares on the count that will be registered this edge
    always_comb begin
        o_full         = (i_count_next == c_full);
        o_empty        = (i_count_next == '0);
        o_almost_full  = (i_count_next >= c_af);
        o_almost_empty = (i_count_next <= c_ae);
    end

endmodule : fifo_flag_gen
`default_nettype wire

// File: rtl/fifo_occupancy_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_occupancy_ctrl
// Description : Write-side pointer and occupancy controller. Accepts
//               push/pop, drives RAM write enable/address one cycle after an
//               accepted push, keeps registered full/empty/almost flags and
//               sticky overflow/underflow errors. Depth comes from fifo_pkg.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_occupancy_ctrl
    import fifo_pkg::*;
#(
    parameter int AF_TH = AF_TH_DEF,
    parameter int AE_TH = AE_TH_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  logic  clear_err,
    output logic  ena_wr,
    output addr_t addr_wr,
    output logic  full_flag,
    output logic  empty_flag,
    output logic  almost_full,
    output logic  almost_empty,
    output cnt_t  count,
    output logic  overflow_err,
    output logic  underflow_err
);

    localparam cnt_t c_full = cnt_t'(W_DEPTH);

    wr_state_t r_wr_state;
    wr_state_t w_wr_state_next;
    addr_t     r_head;
    cnt_t      w_count_next;
    logic      w_push_ok;
    logic      w_pop_ok;
    logic      w_full_next;
    logic      w_empty_next;
    logic      w_af_next;
    logic      w_ae_next;
    logic      w_ovf_set;
    logic      w_udf_set;

    // A pop frees a slot in the same edge, so a full FIFO can still take a push
    assign w_push_ok = push & (~full_flag | pop);
    assign w_pop_ok  = pop & ~empty_flag;
    assign w_ovf_set = push & full_flag & ~pop;
    assign w_udf_set = pop & empty_flag;

    // The address stays on the slot being written until ena_wr drops
    assign addr_wr = r_head;

    // Next occupancy: simultaneous accepted push and pop cancel out
    always_comb begin
        w_count_next = count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = count + cnt_t'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = count - cnt_t'(1);
        end
    end

    fifo_flag_gen #(
        .AF_TH (AF_TH),
        .AE_TH (AE_TH)
    ) u_flag_gen (
        .i_count_next   (w_count_next),
        .o_full         (w_full_next),
        .o_empty        (w_empty_next),
        .o_almost_full  (w_af_next),
        .o_almost_empty (w_ae_next)
    );

    // Write-port state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= WR_IDLE;
        end else begin
            r_wr_state <= w_wr_state_next;
        end
    end

    // Write-port next state and enable; an accepted push always (re)enters WRITE
    always_comb begin
        w_wr_state_next = WR_IDLE;
        ena_wr          = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_push_ok) w_wr_state_next = WR_WRITE;
            end
            WR_WRITE: begin
                ena_wr = 1'b1;
                if (w_push_ok) w_wr_state_next = WR_WRITE;
            end
            default: w_wr_state_next = WR_IDLE;
        endcase
    end

    // Head advances at the edge that ends a WRITE cycle; wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
        end else if (r_wr_state == WR_WRITE) begin
            r_head <= r_head + addr_t'(1);
        end
    end

    // Occupancy and flags update together from the next count
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            full_flag    <= 1'b0;
            empty_flag   <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= w_count_next;
            full_flag    <= w_full_next;
            empty_flag   <= w_empty_next;
            almost_full  <= w_af_next;
            almost_empty <= w_ae_next;
        end
    end

    // Sticky errors; a new error in the clearing cycle wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            overflow_err  <= w_ovf_set | (overflow_err  & ~clear_err);
            underflow_err <= w_udf_set | (underflow_err & ~clear_err);
        end
    end

    a_count_range : assert property (@(posedge clk) disable iff (rst) count <= c_full);

endmodule : fifo_occupancy_ctrl
`default_nettype wire

// File: tb/tb_fifo_occupancy_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_occupancy_ctrl
// Description : Directed self-checking bench for fifo_occupancy_ctrl
//               (W_DEPTH = 8, AF_TH = 6, AE_TH = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_occupancy_ctrl;
    import fifo_pkg::*;

    logic  clk = 1'b0;
    logic  rst, push, pop, clear_err;
    logic  ena_wr, full_flag, empty_flag, almost_full, almost_empty;
    logic  overflow_err, underflow_err;
    addr_t addr_wr;
    cnt_t  count;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_occupancy_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .clear_err     (clear_err),
        .ena_wr        (ena_wr),
        .addr_wr       (addr_wr),
        .full_flag     (full_flag),
        .empty_flag    (empty_flag),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .count         (count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        n_tests++; if (count !== 4'd0)       begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_tests++; if (empty_flag !== 1'b1)  begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty_flag); end
        n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b exp 1", almost_empty); end
        n_tests++; if (full_flag !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b/%b exp 0/0", full_flag, almost_full); end
        n_tests++; if (ena_wr !== 1'b0 || addr_wr !== 3'd0) begin n_fail++; $display("FAIL reset_wr got ena=%b addr=%0d exp 0/0", ena_wr, addr_wr); end
        n_tests++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b/%b exp 0/0", overflow_err, underflow_err); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            push = 1'b1;
            tick();
            n_tests++; if (count !== cnt_t'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
            n_tests++; if (ena_wr !== 1'b1 || addr_wr !== addr_t'(i)) begin n_fail++; $display("FAIL fill_wr[%0d] got ena=%b addr=%0d exp 1/%0d", i, ena_wr, addr_wr, i); end
            n_tests++; if (almost_full !== (i + 1 >= 6)) begin n_fail++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i + 1 >= 6)); end
            n_tests++; if (full_flag !== (i + 1 == 8)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, full_flag, (i + 1 == 8)); end
            n_tests++; if (empty_flag !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d] got %b exp 0", i, empty_flag); end
        end
        push = 1'b0;
        tick();
        n_tests++; if (ena_wr !== 1'b0 || addr_wr !== 3'd0) begin n_fail++; $display("FAIL fill_wrap got ena=%b addr=%0d exp 0/0", ena_wr, addr_wr); end
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_hold got %0d exp 8", count); end
    endtask

    task automatic test_overflow();
        push = 1'b1;
        tick();
        push = 1'b0;
        n_tests++; if (count !== 4'd8 || ena_wr !== 1'b0) begin n_fail++; $display("FAIL ovf_reject got count=%0d ena=%b exp 8/0", count, ena_wr); end
        n_tests++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow_err); end
        repeat (3) tick();
        n_tests++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow_err); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_tests++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", overflow_err); end
    endtask

    task automatic test_full_push_pop();
        push = 1'b1; pop = 1'b1;
        tick();
        push = 1'b0; pop = 1'b0;
        n_tests++; if (count !== 4'd8 || full_flag !== 1'b1) begin n_fail++; $display("FAIL fpp_count got %0d full=%b exp 8/1", count, full_flag); end
        n_tests++; if (ena_wr !== 1'b1 || addr_wr !== 3'd0) begin n_fail++; $display("FAIL fpp_wr got ena=%b addr=%0d exp 1/0", ena_wr, addr_wr); end
        n_tests++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %b exp 0", overflow_err); end
        tick();
        n_tests++; if (ena_wr !== 1'b0 || addr_wr !== 3'd1) begin n_fail++; $display("FAIL fpp_after got ena=%b addr=%0d exp 0/1", ena_wr, addr_wr); end
    endtask

    task automatic test_drain();
        for (int i = 7; i >= 0; i--) begin
            pop = 1'b1;
            tick();
            n_tests++; if (count !== cnt_t'(i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, i); end
            n_tests++; if (almost_empty !== (i <= 2) || empty_flag !== (i == 0)) begin n_fail++; $display("FAIL drain_flags[%0d] got ae=%b e=%b exp %b/%b", i, almost_empty, empty_flag, (i <= 2), (i == 0)); end
            n_tests++; if (full_flag !== 1'b0 || ena_wr !== 1'b0) begin n_fail++; $display("FAIL drain_wr[%0d] got full=%b ena=%b exp 0/0", i, full_flag, ena_wr); end
        end
        pop = 1'b0;
        n_tests++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL drain_udf got %b exp 0", underflow_err); end
    endtask

    task automatic test_underflow();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        n_tests++; if (underflow_err !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL udf_pop got err=%b count=%0d exp 1/0", underflow_err, count); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_tests++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL udf_clear got %b exp 0", underflow_err); end
        push = 1'b1; pop = 1'b1;
        tick();
        push = 1'b0; pop = 1'b0;
        n_tests++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL udf_pp got %b exp 1", underflow_err); end
        n_tests++; if (count !== 4'd1 || empty_flag !== 1'b0) begin n_fail++; $display("FAIL udf_pp_count got %0d empty=%b exp 1/0", count, empty_flag); end
        n_tests++; if (ena_wr !== 1'b1 || addr_wr !== 3'd1) begin n_fail++; $display("FAIL udf_pp_wr got ena=%b addr=%0d exp 1/1", ena_wr, addr_wr); end
        pop = 1'b1;
        tick();
        n_tests++; if (count !== 4'd0 || empty_flag !== 1'b1 || underflow_err !== 1'b1) begin n_fail++; $display("FAIL udf_drain got count=%0d e=%b err=%b exp 0/1/1", count, empty_flag, underflow_err); end
        // Still empty: a clear in the same cycle as a fresh underflow must lose
        clear_err = 1'b1;
        tick();
        pop = 1'b0;
        n_tests++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL udf_setwins got %b exp 1", underflow_err); end
        tick();
        clear_err = 1'b0;
        n_tests++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL udf_clear2 got %b exp 0", underflow_err); end
    endtask

    task automatic test_mid_reset();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        push = 1'b1;
        repeat (4) tick();
        n_tests++; if (count !== 4'd4 || ena_wr !== 1'b1) begin n_fail++; $display("FAIL mrst_pre got count=%0d ena=%b exp 4/1", count, ena_wr); end
        rst = 1'b1;
        tick();
        n_tests++; if (count !== 4'd0 || empty_flag !== 1'b1 || almost_empty !== 1'b1) begin n_fail++; $display("FAIL mrst_count got %0d e=%b ae=%b exp 0/1/1", count, empty_flag, almost_empty); end
        n_tests++; if (ena_wr !== 1'b0 || addr_wr !== 3'd0) begin n_fail++; $display("FAIL mrst_wr got ena=%b addr=%0d exp 0/0", ena_wr, addr_wr); end
        n_tests++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL mrst_err got %b/%b exp 0/0", overflow_err, underflow_err); end
        rst = 1'b0; push = 1'b0;
        tick();
        n_tests++; if (count !== 4'd0 || ena_wr !== 1'b0) begin n_fail++; $display("FAIL mrst_idle got count=%0d ena=%b exp 0/0", count, ena_wr); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_drain();
        test_underflow();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fifo_occupancy_ctrl
`default_nettype wire
